prog_loader: RTL
================

Name: prog_loader

Overview:
- Byte-stream program loader; the write side of the program-memory interface that the single-cycle datapath only reads.
- Receives a length-prefixed byte stream through a valid/ready handshake.
- Assembles 16-bit instruction words and writes them to program memory at consecutive addresses starting at 0.
- Holds the CPU in reset while loading.

Parameters:
- AW, 10, program-memory address width. Also the width of the word count.
- DW, 16, instruction width. Fixed at 2 bytes per word, high byte first.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request to begin a load.
- byte_in  in  8  stream byte.
- byte_valid  in  1  byte_in is valid.
- byte_ready  out  1  loader accepts byte_in this cycle.
- we_prog  out  1  program-memory write enable.
- addr_prog  out  AW  program-memory write address.
- data_prog  out  DW  program-memory write data.
- cpu_hold  out  1  keep CPU in reset while high.
- done  out  1  load completed successfully.
- error  out  1  load aborted on a bad stream.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE.
  - byte_ready, we_prog, cpu_hold, done, error all =0.
  - addr_prog=0, data_prog=0.
  - Internal word index and length cleared.
  - Reset mid-load behaves identically. Partially written memory is left as is.
- Handshake: a byte is accepted only at a clk edge where byte_valid&&byte_ready. byte_ready is a registered function of state only.
- States:
  - IDLE: ready=0. On start: go to LEN_HI, cpu_hold=1, done=0, error=0, index=0.
  - LEN_HI: ready=1. On accept: if byte[7:2]!=0, go to ERR. Otherwise store len[9:8]=byte[1:0] and go to LEN_LO.
  - LEN_LO: ready=1. On accept: len[7:0]=byte. If the full len==0, go to FINISH. Otherwise go to WORD_HI.
  - WORD_HI: ready=1. On accept: data_prog[15:8]=byte, go to WORD_LO.
  - WORD_LO: ready=1. On accept: data_prog[7:0]=byte, addr_prog=index, go to WRITE.
  - WRITE: ready=0, we_prog=1 for exactly this one cycle. Then index+=1. If the new index==len, go to FINISH. Otherwise go to WORD_HI.
  - DONE: ready=0, cpu_hold=0, done=1. Holds until start, which begins a new load as from IDLE.
  - ERR: ready=0, cpu_hold=1, error=1. Holds until start, which begins a new load; or until reset.
- FINISH = DONE, or CHK when the optional feature is enabled.
- Latency: we_prog asserts on the first cycle after the WORD_LO byte is accepted. Minimum 3 cycles per word at full rate.
- The cpu_hold falling edge and the done rising edge occur in the same cycle.
- start is ignored in every state except IDLE, DONE and ERR.
- Index does not wrap: the maximum len is 1023, so the last address is 1022.
- we_prog is never asserted in IDLE, DONE or ERR.

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN.
- Enabled:
  - An 8-bit running sum (mod 256) of all word bytes (not the length bytes) is kept. It is cleared on start.
  - After the last WRITE (or after LEN_LO when len==0), the loader enters CHK with ready=1.
  - The accepted byte is compared with the sum: equal goes to DONE, different goes to ERR.
- Disabled: there is no CHK state; FINISH goes directly to DONE.

Test Plan:
- Stream 00 02 12 34 AB CD at full rate after start -> we_prog pulses at addr 0 with data 0x1234, then at addr 1 with data 0xABCD. Then done=1 and cpu_hold=0 in the same cycle. error=0.
- Stream 00 00 -> no we_prog pulse, done=1. With CHECKSUM_EN, a trailing 00 is also required.
- Stream 04 00 -> error=1 after the first byte, cpu_hold stays 1, byte_ready=0, no we_prog. A subsequent start plus a valid stream -> done=1.
- Stream 00 01 12 34 with byte_valid dropped for 3 cycles between bytes -> byte_ready=0 during WRITE. Exactly one write at addr 0 with data 0x1234, and no byte is lost or duplicated.
- Assert reset=0 for one cycle after the first WRITE of a 3-word load -> all outputs return to reset values. A new start plus a 1-word stream writes addr 0 and sets done=1.
- With CHECKSUM_EN, stream 00 01 12 34 46 -> done=1. Stream 00 01 12 34 47 -> error=1 and cpu_hold=1.

Source files
------------

// File: rtl/prog_loader_if.sv
// Byte-stream and program-memory write bundle for prog_loader.
// master = stream source / memory side, slave = loader.
interface prog_loader_if #(
  parameter int AW = 10,
  parameter int DW = 16
);
  logic [7:0]    byte_in;
  logic          byte_valid;
  logic          byte_ready;
  logic          we_prog;
  logic [AW-1:0] addr_prog;
  logic [DW-1:0] data_prog;

  modport master (
    output byte_in, byte_valid,
    input  byte_ready, we_prog, addr_prog, data_prog
  );

  modport slave (
    input  byte_in, byte_valid,
    output byte_ready, we_prog, addr_prog, data_prog
  );
endinterface

// File: rtl/prog_loader.sv
// Length-prefixed byte-stream loader that fills program memory from address 0.
// Define PROG_LOADER_CHECKSUM_EN to require a trailing mod-256 byte checksum.
module prog_loader #(
  parameter int AW = 10,
  parameter int DW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  prog_loader_if.slave    bus,
  output logic            cpu_hold,
  output logic            done,
  output logic            error
);
  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_LEN_HI  = 4'd1;
  localparam logic [3:0] S_LEN_LO  = 4'd2;
  localparam logic [3:0] S_WORD_HI = 4'd3;
  localparam logic [3:0] S_WORD_LO = 4'd4;
  localparam logic [3:0] S_WRITE   = 4'd5;
  localparam logic [3:0] S_DONE    = 4'd6;
  localparam logic [3:0] S_ERR     = 4'd7;
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam logic [3:0] S_CHK     = 4'd8;
  localparam logic [3:0] S_FINISH  = S_CHK;
`else
  localparam logic [3:0] S_FINISH  = S_DONE;
`endif

  logic [3:0]    state;
  logic [AW-1:0] idx;
  logic [AW-1:0] idx_inc;
  logic [AW-1:0] len;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  logic [7:0]    b;
  logic          acc;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]    sum;
`endif

  assign b       = bus.byte_in;
  assign acc     = bus.byte_valid && bus.byte_ready;
  assign idx_inc = idx + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
      idx   <= '0;
      len   <= '0;
      addr  <= '0;
      data  <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum   <= '0;
`endif
    end else begin
      unique case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state <= S_LEN_HI;
            idx   <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum   <= '0;
`endif
          end
        end
        S_LEN_HI: begin
          if (acc) begin
            if (|b[7:2]) begin
              state <= S_ERR;
            end else begin
              len   <= AW'(b[1:0]) << 8;
              state <= S_LEN_LO;
            end
          end
        end
        S_LEN_LO: begin
          if (acc) begin
            len[7:0] <= b;
            // Zero-length load skips straight to completion
            if (len[AW-1:8] == '0 && b == 8'h00)
              state <= S_FINISH;
            else
              state <= S_WORD_HI;
          end
        end
        S_WORD_HI: begin
          if (acc) begin
            data[DW-1:8] <= b;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum          <= sum + b;
`endif
            state        <= S_WORD_LO;
          end
        end
        S_WORD_LO: begin
          if (acc) begin
            data[7:0] <= b;
            addr      <= idx;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum       <= sum + b;
`endif
            state     <= S_WRITE;
          end
        end
        S_WRITE: begin
          idx   <= idx_inc;
          state <= (idx_inc == len) ? S_FINISH : S_WORD_HI;
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (acc)
            state <= (b == sum) ? S_DONE : S_ERR;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  assign bus.byte_ready = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                          (state == S_WORD_HI) || (state == S_WORD_LO) ||
                          (state == S_CHK);
`else
  assign bus.byte_ready = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                          (state == S_WORD_HI) || (state == S_WORD_LO);
`endif

  assign bus.we_prog   = (state == S_WRITE);
  assign bus.addr_prog = addr;
  assign bus.data_prog = data;
  assign cpu_hold      = (state != S_IDLE) && (state != S_DONE);
  assign done          = (state == S_DONE);
  assign error         = (state == S_ERR);
endmodule
